// File: rtl/cdu_count_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdu_req_pkg
// Purpose : Shared types and helpers for the CDU counter-increment requester.
//           Holds the request state encoding, the latched direction values
//           and a saturating signed add used for the backlog update.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cdu_req_pkg;

   // Request state machine encoding
   typedef logic [1:0] state_t;
   localparam state_t c_st_idle    = 2'd0;
   localparam state_t c_st_req     = 2'd1;
   localparam state_t c_st_release = 2'd2;

   // Direction latched when a request is raised
   localparam logic c_dir_plus  = 1'b0;
   localparam logic c_dir_minus = 1'b1;

   typedef struct packed {
      logic signed [31:0] value;
      logic               dropped;
   } sat_result_t;

   // Adds delta to base unless the sum leaves [-limit, +limit]. When it
   // would, the delta is discarded (reported through 'dropped' only if
   // there was a nonzero delta to lose) and base itself is clamped, which
   // covers a retire that pushed base one step past the limit.
   function automatic sat_result_t sat_add(
      input logic signed [31:0] base,
      input logic signed [31:0] delta,
      input logic signed [31:0] limit
   );
      sat_result_t        r;
      logic signed [31:0] sum;
      sum       = base + delta;
      r.value   = sum;
      r.dropped = 1'b0;
      if ((sum > limit) || (sum < -limit)) begin
         r.dropped = (delta != 32'sd0);
         if (base > limit) begin
            r.value = limit;
         end else if (base < -limit) begin
            r.value = -limit;
         end else begin
            r.value = base;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdu_count_requester_if.sv
`default_nettype none
// ============================================================================
// Module  : cdu_count_requester_if
// Purpose : AGC-facing counter request bus.
// Signals : PCDU     - plus-count request     (requester -> AGC)
//           MCDU     - minus-count request    (requester -> AGC)
//           CDUSTB_n - acknowledge strobe, active-low, asynchronous level
//                                             (AGC -> requester)
//           GOJAM    - AGC restart, synchronous clear (AGC -> requester)
// Modports: master - the requester; slave - the AGC side.
// Revision: 1.0 - initial release
// ============================================================================
interface cdu_count_requester_if;
   logic PCDU;
   logic MCDU;
   logic CDUSTB_n;
   logic GOJAM;

   modport master (
      output PCDU,
      output MCDU,
      input  CDUSTB_n,
      input  GOJAM
   );

   modport slave (
      input  PCDU,
      input  MCDU,
      output CDUSTB_n,
      output GOJAM
   );
endinterface
`default_nettype wire

// File: rtl/cdu_count_requester_strobe_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : strobe_edge_det
// Purpose : Brings an asynchronous active-low strobe into the clock domain
//           through two flops and flags its falling edge. Flops preset to 1
//           so a strobe idling high produces no spurious edge out of reset.
// Ports   : clk           - clock, rising edge
//           rst_n         - asynchronous active-low reset
//           i_strobe_n    - asynchronous active-low strobe
//           o_strobe_sync - synchronized strobe level
//           o_fall        - one-cycle pulse: synchronized strobe went 1 -> 0
// Revision: 1.0 - initial release
// ============================================================================
module strobe_edge_det (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_strobe_n,
   output logic      o_strobe_sync,
   output logic      o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_strobe_n;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_strobe_sync = r_sync;
   assign o_fall        = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/cdu_count_requester.sv
`default_nettype none
// ============================================================================
// Module  : cdu_count_requester
// Purpose : External-device side of the AGC counter-increment interface.
//           Accumulates encoder up/down pulses into a signed backlog and
//           presents one PCDU (plus) or MCDU (minus) request at a time,
//           retiring it on the AGC's CDUSTB_n acknowledge strobe.
// Ports   : CLOCK     - system clock, rising edge
//           SIM_RST   - asynchronous active-low reset
//           UP_PULSE  - one-cycle encoder increment pulse
//           DN_PULSE  - one-cycle encoder decrement pulse
//           ERR_CLR   - synchronous clear of the sticky error flags
//           agc       - AGC bus (PCDU, MCDU out; CDUSTB_n, GOJAM in)
//           BACKLOG   - signed pending count, two's complement
//           OVF_ERR   - sticky, a pulse was dropped at saturation
//           TMO_ERR   - sticky, a request waited ACK_TIMEOUT cycles
//           BUSY      - state machine is not idle
// Revision: 1.0 - initial release
// ============================================================================
module cdu_count_requester
   import cdu_req_pkg::*;
#(
   parameter int BACKLOG_W   = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  wire logic                    CLOCK,
   input  wire logic                    SIM_RST,
   input  wire logic                    UP_PULSE,
   input  wire logic                    DN_PULSE,
   input  wire logic                    ERR_CLR,
   cdu_count_requester_if.master        agc,
   output logic signed [BACKLOG_W-1:0] BACKLOG,
   output logic                         OVF_ERR,
   output logic                         TMO_ERR,
   output logic                         BUSY
);

   localparam logic signed [31:0] c_limit =
      (32'sd1 <<< (BACKLOG_W - 1)) - 32'sd1;
   localparam int                 c_tmo_w   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(ACK_TIMEOUT);
   localparam logic [c_tmo_w-1:0] c_tmo_pre = c_tmo_w'(ACK_TIMEOUT - 1);

   // Registered state
   state_t                      r_state;
   logic                        r_pcdu;
   logic                        r_mcdu;
   logic                        r_dir;
   logic [c_tmo_w-1:0]          r_tmo_cnt;
   logic signed [BACKLOG_W-1:0] r_backlog;
   logic                        r_ovf;
   logic                        r_tmo;

   // Next-state and helper terms
   state_t                      w_state_nxt;
   logic                        w_pcdu_nxt;
   logic                        w_mcdu_nxt;
   logic                        w_dir_nxt;
   logic [c_tmo_w-1:0]          w_tmo_cnt_nxt;
   logic signed [BACKLOG_W-1:0] w_backlog_nxt;
   logic signed [31:0]          w_retire;
   logic signed [31:0]          w_pulse;
   logic signed [31:0]          w_base;
   sat_result_t                 w_sat;
   logic                        w_tmo_set;
   logic                        w_ovf_set;
   logic                        w_stb_sync;
   logic                        w_ack;

   strobe_edge_det u_stb (
      .clk           (CLOCK),
      .rst_n         (SIM_RST),
      .i_strobe_n    (agc.CDUSTB_n),
      .o_strobe_sync (w_stb_sync),
      .o_fall        (w_ack)
   );

   // Request sequencing
   always_comb begin
      w_state_nxt   = r_state;
      w_pcdu_nxt    = r_pcdu;
      w_mcdu_nxt    = r_mcdu;
      w_dir_nxt     = r_dir;
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_retire      = 32'sd0;
      w_tmo_set     = 1'b0;

      if (agc.GOJAM) begin
         // Restart: drop everything, but do not re-enter IDLE while the
         // AGC is still holding its strobe low.
         w_pcdu_nxt    = 1'b0;
         w_mcdu_nxt    = 1'b0;
         w_tmo_cnt_nxt = '0;
         w_state_nxt   = w_stb_sync ? c_st_idle : c_st_release;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (r_backlog > $signed({BACKLOG_W{1'b0}})) begin
                  w_pcdu_nxt    = 1'b1;
                  w_dir_nxt     = c_dir_plus;
                  w_tmo_cnt_nxt = '0;
                  w_state_nxt   = c_st_req;
               end else if (r_backlog < $signed({BACKLOG_W{1'b0}})) begin
                  w_mcdu_nxt    = 1'b1;
                  w_dir_nxt     = c_dir_minus;
                  w_tmo_cnt_nxt = '0;
                  w_state_nxt   = c_st_req;
               end
            end

            c_st_req: begin
               if (w_ack) begin
                  // Retire against the direction latched at request time,
                  // regardless of what the backlog has done since.
                  w_pcdu_nxt    = 1'b0;
                  w_mcdu_nxt    = 1'b0;
                  w_retire      = (r_dir == c_dir_plus) ? 32'sd1 : -32'sd1;
                  w_tmo_cnt_nxt = '0;
                  w_state_nxt   = c_st_release;
               end else begin
                  if (r_tmo_cnt != c_tmo_max) begin
                     w_tmo_cnt_nxt = r_tmo_cnt + c_tmo_w'(1);
                  end
                  // Flag on the edge the counter lands on ACK_TIMEOUT and
                  // every cycle it stays there; the request keeps going.
                  if (r_tmo_cnt >= c_tmo_pre) begin
                     w_tmo_set = 1'b1;
                  end
               end
            end

            c_st_release: begin
               if (w_stb_sync) begin
                  w_state_nxt = c_st_idle;
               end
            end

            default: begin
               w_pcdu_nxt    = 1'b0;
               w_mcdu_nxt    = 1'b0;
               w_tmo_cnt_nxt = '0;
               w_state_nxt   = c_st_idle;
            end
         endcase
      end
   end

   // Backlog arithmetic: simultaneous up/down cancel before saturation is
   // considered, so they can never raise an overflow.
   always_comb begin
      if (UP_PULSE && !DN_PULSE) begin
         w_pulse = 32'sd1;
      end else if (DN_PULSE && !UP_PULSE) begin
         w_pulse = -32'sd1;
      end else begin
         w_pulse = 32'sd0;
      end
      w_base    = 32'(r_backlog) - w_retire;
      w_sat     = sat_add(w_base, w_pulse, c_limit);
      w_ovf_set = w_sat.dropped & ~agc.GOJAM;
      if (agc.GOJAM) begin
         w_backlog_nxt = '0;
      end else begin
         w_backlog_nxt = BACKLOG_W'(w_sat.value);
      end
   end

   always_ff @(posedge CLOCK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         r_state   <= c_st_idle;
         r_pcdu    <= 1'b0;
         r_mcdu    <= 1'b0;
         r_dir     <= c_dir_plus;
         r_tmo_cnt <= '0;
         r_backlog <= '0;
         r_ovf     <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pcdu    <= w_pcdu_nxt;
         r_mcdu    <= w_mcdu_nxt;
         r_dir     <= w_dir_nxt;
         r_tmo_cnt <= w_tmo_cnt_nxt;
         r_backlog <= w_backlog_nxt;
         // A set in the same cycle as a clear wins.
         r_ovf     <= w_ovf_set | (r_ovf & ~ERR_CLR);
         r_tmo     <= w_tmo_set | (r_tmo & ~ERR_CLR);
      end
   end

   assign agc.PCDU = r_pcdu;
   assign agc.MCDU = r_mcdu;
   assign BACKLOG  = r_backlog;
   assign OVF_ERR  = r_ovf;
   assign TMO_ERR  = r_tmo;
   assign BUSY     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_cdu_count_requester.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdu_count_requester
// Purpose : Self-checking bench for cdu_count_requester. Directed scenarios
//           followed by a randomized run, all compared every cycle against
//           a behavioural model of the request/ack protocol.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdu_count_requester;

   localparam int BW  = 8;
   localparam int TMO = 255;
   localparam int LIM = 127;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 up;
   logic                 dn;
   logic                 err_clr;
   logic signed [BW-1:0] backlog;
   logic                 ovf;
   logic                 tmo;
   logic                 busy;

   cdu_count_requester_if bus();

   cdu_count_requester #(
      .BACKLOG_W   (BW),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .CLOCK    (clk),
      .SIM_RST  (rst_n),
      .UP_PULSE (up),
      .DN_PULSE (dn),
      .ERR_CLR  (err_clr),
      .agc      (bus),
      .BACKLOG  (backlog),
      .OVF_ERR  (ovf),
      .TMO_ERR  (tmo),
      .BUSY     (busy)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   // Behavioural model
   int m_backlog;   // pending count
   int m_req;       // outstanding request: +1 plus, -1 minus, 0 none
   int m_phase;     // 0 quiet, 1 waiting for ack, 2 waiting for strobe release
   int m_wait;      // cycles spent waiting for ack
   bit m_ovf;
   bit m_tmo;
   bit h1, h2, h3;  // strobe samples from 1, 2 and 3 edges ago

   task automatic model_reset();
      m_backlog = 0; m_req = 0; m_phase = 0; m_wait = 0;
      m_ovf = 0; m_tmo = 0;
      h1 = 1; h2 = 1; h3 = 1;
   endtask

   task automatic model_step();
      bit ack, sync, tmo_set, ovf_set;
      int d, retire, b;
      ack = h3 && !h2;   // strobe seen high then low after two-flop delay
      sync = h2;
      retire = 0; tmo_set = 0; ovf_set = 0;
      if (bus.GOJAM) begin
         m_backlog = 0; m_req = 0; m_wait = 0;
         m_phase = sync ? 0 : 2;
      end else begin
         case (m_phase)
            0: if (m_backlog != 0) begin
                  m_req = (m_backlog > 0) ? 1 : -1;
                  m_phase = 1; m_wait = 0;
               end
            1: if (ack) begin
                  retire = m_req; m_req = 0; m_phase = 2; m_wait = 0;
               end else begin
                  if (m_wait < TMO) m_wait++;
                  if (m_wait == TMO) tmo_set = 1;
               end
            default: if (sync) m_phase = 0;
         endcase
         d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
         b = m_backlog - retire;
         if (b + d > LIM || b + d < -LIM) begin
            ovf_set = (d != 0);
            b = (b > LIM) ? LIM : ((b < -LIM) ? -LIM : b);
         end else begin
            b = b + d;
         end
         m_backlog = b;
      end
      m_ovf = ovf_set | (m_ovf & !err_clr);
      m_tmo = tmo_set | (m_tmo & !err_clr);
      h3 = h2; h2 = h1; h1 = bus.CDUSTB_n;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("pcdu",      bus.PCDU, (m_req == 1)  ? 1 : 0);
      chk("mcdu",      bus.MCDU, (m_req == -1) ? 1 : 0);
      chk("backlog",   backlog,  m_backlog);
      chk("ovf_err",   ovf,      m_ovf);
      chk("tmo_err",   tmo,      m_tmo);
      chk("busy",      busy,     (m_phase != 0) ? 1 : 0);
      chk("exclusive", bus.PCDU & bus.MCDU, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic ack_cycle();
      bus.CDUSTB_n = 1'b0;
      repeat (4) tick();
      bus.CDUSTB_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      int bias;
      rst_n = 1'b0; up = 1'b0; dn = 1'b0; err_clr = 1'b0;
      bus.CDUSTB_n = 1'b1; bus.GOJAM = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      chk("rst_backlog", backlog, 0);
      chk("rst_pcdu", bus.PCDU, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // Three up pulses, three acks
      up = 1'b1; tick();
      chk("t1_first_backlog", backlog, 1);
      chk("t1_pcdu_not_yet", bus.PCDU, 0);
      tick();
      chk("t1_pcdu_next_cycle", bus.PCDU, 1);
      tick(); up = 1'b0;
      chk("t1_backlog3", backlog, 3);
      for (int k = 0; k < 3; k++) begin
         ack_cycle();
         chk("t1_retire", backlog, 2 - k);
      end
      chk("t1_pcdu_final", bus.PCDU, 0);
      chk("t1_mcdu_final", bus.MCDU, 0);

      // Opposite pulses while a plus request is pending
      up = 1'b1; tick(); tick(); up = 1'b0;
      chk("t2_backlog2", backlog, 2);
      tick();
      chk("t2_pcdu", bus.PCDU, 1);
      dn = 1'b1; repeat (4) tick(); dn = 1'b0;
      chk("t2_backlog_neg2", backlog, -2);
      chk("t2_pcdu_held", bus.PCDU, 1);
      bus.CDUSTB_n = 1'b0; repeat (4) tick();
      chk("t2_backlog_neg3", backlog, -3);
      chk("t2_pcdu_dropped", bus.PCDU, 0);
      bus.CDUSTB_n = 1'b1; repeat (4) tick();
      chk("t2_mcdu", bus.MCDU, 1);
      bus.GOJAM = 1'b1; tick(); bus.GOJAM = 1'b0;
      chk("t2_gojam_backlog", backlog, 0);
      tick();

      // Simultaneous up/down cancel
      up = 1'b1; dn = 1'b1; repeat (10) tick(); up = 1'b0; dn = 1'b0;
      chk("t3_backlog", backlog, 0);
      chk("t3_pcdu", bus.PCDU, 0);
      chk("t3_ovf", ovf, 0);

      // Saturation
      up = 1'b1; repeat (130) tick(); up = 1'b0;
      chk("t4_sat", backlog, LIM);
      chk("t4_ovf", ovf, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t4_ovf_clr", ovf, 0);
      chk("t4_sat_kept", backlog, LIM);
      bus.GOJAM = 1'b1; tick(); bus.GOJAM = 1'b0;
      tick();

      // Acknowledge timeout
      up = 1'b1; tick(); up = 1'b0; tick();
      chk("t5_pcdu", bus.PCDU, 1);
      repeat (TMO - 1) tick();
      chk("t5_tmo_early", tmo, 0);
      tick();
      chk("t5_tmo", tmo, 1);
      chk("t5_pcdu_still", bus.PCDU, 1);
      ack_cycle();
      chk("t5_retired", backlog, 0);
      chk("t5_pcdu_off", bus.PCDU, 0);

      // GOJAM during a request
      up = 1'b1; repeat (5) tick(); up = 1'b0;
      chk("t6_backlog5", backlog, 5);
      chk("t6_pcdu", bus.PCDU, 1);
      bus.GOJAM = 1'b1; tick(); bus.GOJAM = 1'b0;
      chk("t6_pcdu_off", bus.PCDU, 0);
      chk("t6_backlog0", backlog, 0);
      chk("t6_tmo_kept", tmo, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t6_tmo_clr", tmo, 0);

      // Asynchronous reset mid-request
      up = 1'b1; tick(); up = 1'b0; tick();
      chk("t7_pcdu", bus.PCDU, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_async_pcdu", bus.PCDU, 0);
      chk("t7_async_busy", busy, 0);
      chk("t7_async_backlog", backlog, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Randomized run
      for (int c = 0; c < 3000; c++) begin
         bias = (c < 1000) ? 1 : 3;
         up = ($urandom_range(0, 3) < bias);
         dn = ($urandom_range(0, 3) < (4 - bias)) && ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 4) == 0) bus.CDUSTB_n = ~bus.CDUSTB_n;
         bus.GOJAM = ($urandom_range(0, 299) == 0);
         err_clr   = ($urandom_range(0, 59) == 0);
         tick();
      end
      up = 1'b0; dn = 1'b0; bus.GOJAM = 1'b0; err_clr = 1'b0;
      bus.CDUSTB_n = 1'b1;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cdu_count_requester.md
Name: cdu_count_requester

Overview:
- External-device side of the counter-increment request interface serviced by the AGC priority/crosspoint logic.
- Accumulates angle-encoder up/down pulses into a signed backlog.
- Presents one PCDU (plus) or MCDU (minus) request at a time, and retires each request on the AGC's CDUSTB_n strobe.
- Sits between a CDU/encoder model and the agc top-level PCDU/MCDU/CDUSTB_n pins.

Parameters:
- BACKLOG_W, 8, width of the signed backlog counter; the saturation limit is ±(2^(BACKLOG_W-1)-1).
- ACK_TIMEOUT, 255, number of CLOCK cycles a request may stay unacknowledged before TMO_ERR is set.

Ports:
- CLOCK  input  1  system clock, rising edge.
- SIM_RST  input  1  reset, asynchronous, active-low.
- UP_PULSE  input  1  one-cycle encoder increment pulse, synchronous to CLOCK.
- DN_PULSE  input  1  one-cycle encoder decrement pulse, synchronous to CLOCK.
- CDUSTB_n  input  1  AGC acknowledge strobe, active-low, asynchronous level.
- GOJAM  input  1  AGC restart; synchronous clear of requests.
- ERR_CLR  input  1  synchronous clear of the sticky error flags.
- PCDU  output  1  plus-count request to the AGC.
- MCDU  output  1  minus-count request to the AGC.
- BACKLOG  output  BACKLOG_W  signed pending count, two's complement.
- OVF_ERR  output  1  sticky; set when a pulse is dropped at saturation.
- TMO_ERR  output  1  sticky; set on acknowledge timeout.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset (SIM_RST low, asynchronous):
  - All outputs 0, BACKLOG = 0, state = IDLE, timeout counter = 0.
  - Synchronizer flops preset to 1 (strobe idle-high).
- CDUSTB_n handling:
  - Passes through a 2-flop synchronizer.
  - An ack event is a falling edge of the synchronized signal (previous 1, current 0), giving 3 cycles of input latency.
- Backlog update, every cycle: next = BACKLOG + up - dn - retire.
  - up = UP_PULSE & ~DN_PULSE; dn = DN_PULSE & ~UP_PULSE. Simultaneous UP and DN cancel, with no change and no error.
  - retire = +1 if an ack retires a PCDU, -1 if an ack retires an MCDU, else 0.
  - Retire is always applied. If the pulse term would push the backlog beyond ±limit, that pulse is dropped and OVF_ERR is set.
- State machine (encoding in package):
  - IDLE: if BACKLOG > 0, assert PCDU, latch dir = PLUS, go REQ. If BACKLOG < 0, assert MCDU, latch dir = MINUS, go REQ. If zero, stay. The request is asserted the cycle after the backlog becomes nonzero.
  - REQ: hold the latched request line; timeout counter increments each cycle.
    - On an ack event: deassert the request, apply retire per the latched dir, clear the timeout counter, go RELEASE.
    - When the counter reaches ACK_TIMEOUT: set TMO_ERR, saturate the counter, keep requesting.
  - RELEASE: wait for synchronized CDUSTB_n = 1, then go IDLE. The minimum gap between requests is 1 cycle in RELEASE plus 1 cycle in IDLE.
- Direction is latched at REQ entry. Opposite pulses during REQ do not withdraw the request. After an ack, the backlog may become zero or change sign; it is served on the next IDLE evaluation.
- PCDU and MCDU are never high together.
- GOJAM (synchronous, highest priority after reset):
  - BACKLOG = 0, request lines drop the same edge, timeout counter cleared.
  - State goes IDLE if no strobe is low, else RELEASE.
  - Error flags are retained.
- ERR_CLR: clears OVF_ERR and TMO_ERR. If a set condition occurs in the same cycle, set wins.
- Reset asserted mid-request: outputs drop immediately and asynchronously.

Decomposition:
- Package cdu_req_pkg holds:
  - state enum {IDLE, REQ, RELEASE};
  - dir constants PLUS/MINUS;
  - function for the saturating signed add.
- One sub-module, strobe_edge_det: 2-flop synchronizer plus falling-edge detect, with active-low async reset presetting to 1. It is reused by other counter requesters (PINC/MINC).

Test Plan:
- Three UP_PULSE, then CDUSTB_n low for 4 cycles and high, repeated 3 times -> PCDU high 1 cycle after the first pulse; BACKLOG goes 3→2→1→0; PCDU stays low after the third ack; MCDU never asserts.
- BACKLOG = 2 and PCDU pending; inject 4 DN_PULSE, then ack -> PCDU held until the ack; BACKLOG goes 2→-2→-3; after RELEASE, MCDU asserts.
- UP_PULSE and DN_PULSE together for 10 cycles -> BACKLOG stays 0; no request; no OVF_ERR.
- 130 UP_PULSE with no acks (BACKLOG_W = 8) -> BACKLOG saturates at 127; OVF_ERR = 1; ERR_CLR clears it while BACKLOG stays 127.
- Request with no strobe for 256 cycles -> TMO_ERR = 1 at cycle ACK_TIMEOUT; PCDU still high; a later ack retires normally.
- GOJAM while in REQ with BACKLOG = 5 -> PCDU low at the next edge; BACKLOG = 0; TMO_ERR retained. Separately, SIM_RST low mid-REQ -> PCDU low with no clock edge.
